// File: rtl/frog_controller.sv
// Player frog sequencer: debounced presses become single-cell moves applied at frame start.
// Optional win counter on the score port when FROG_SCORE_EN is defined.
module frog_controller #(
  parameter int GRID_SIZE       = 32,
  parameter int GRID_COLS       = 20,
  parameter int GRID_ROWS       = 15,
  parameter int START_COL       = 10,
  parameter int START_ROW       = 14,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int WIN_FRAMES      = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [9:0] h_counter,
  input  logic [9:0] v_counter,
  output logic [4:0] frog_col,
  output logic [3:0] frog_row,
  output logic       in_frog,
  output logic       win_pulse,
  output logic       busy
`ifdef FROG_SCORE_EN
  ,
  output logic [3:0] score
`endif
);

  localparam int SHIFT   = $clog2(GRID_SIZE);
  localparam int CNT_MAX = (WIN_FRAMES > COOLDOWN_FRAMES) ?
                           WIN_FRAMES : COOLDOWN_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE, PENDING, COOLDOWN, WIN
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT
  } dir_e;

  logic [3:0]       btn;
  logic [3:0]       arm_q, arm_d;
  logic [3:0]       press_q, press_d;
  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       col_q, col_d, mv_col;
  logic [3:0]       row_q, row_d, mv_row;
  logic             in_frog_q, in_frog_d;
  logic             win_q, win_d;
  logic             busy_q, busy_d;
  logic [9:0]       h_cell, v_cell;
`ifdef FROG_SCORE_EN
  logic [3:0]       score_q, score_d;
`endif

  assign btn = {btn_up, btn_down, btn_left, btn_right};

  // arm_q holds "button was released"; resetting it to 0 means a
  // button held through reset release never counts as a press.
  always_comb begin
    arm_d   = ~btn;
    press_d = btn & arm_q;
  end

  always_comb begin
    mv_col = col_q;
    mv_row = row_q;
    unique case (dir_q)
      DIR_UP:
        if (row_q != 4'd0) mv_row = row_q - 4'd1;
      DIR_DOWN:
        if (row_q != 4'(GRID_ROWS - 1)) mv_row = row_q + 4'd1;
      DIR_LEFT:
        if (col_q != 5'd0) mv_col = col_q - 5'd1;
      DIR_RIGHT:
        if (col_q != 5'(GRID_COLS - 1)) mv_col = col_q + 5'd1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|press_q) begin
          state_d = PENDING;
          if (press_q[3])      dir_d = DIR_UP;
          else if (press_q[2]) dir_d = DIR_DOWN;
          else if (press_q[1]) dir_d = DIR_LEFT;
          else                 dir_d = DIR_RIGHT;
        end
      end
      PENDING: begin
        if (frame_start) begin
          col_d = mv_col;
          row_d = mv_row;
          if (mv_row == 4'd0) begin
            state_d = WIN;
            cnt_d   = CNT_W'(WIN_FRAMES);
            win_d   = 1'b1;
          end else begin
            state_d = COOLDOWN;
            cnt_d   = CNT_W'(COOLDOWN_FRAMES);
          end
        end
      end
      COOLDOWN: begin
        if (frame_start) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = IDLE;
        end
      end
      WIN: begin
        if (frame_start) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            col_d   = 5'(START_COL);
            row_d   = 4'(START_ROW);
          end
        end
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    h_cell    = h_counter >> SHIFT;
    v_cell    = v_counter >> SHIFT;
    in_frog_d = (h_cell == {5'd0, col_q}) &&
                (v_cell == {6'd0, row_q}) &&
                (h_counter < 10'(GRID_COLS * GRID_SIZE)) &&
                (v_counter < 10'(GRID_ROWS * GRID_SIZE));
  end

`ifdef FROG_SCORE_EN
  always_comb begin
    score_d = score_q;
    if (win_d && score_q != 4'hf) score_d = score_q + 4'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arm_q     <= '0;
      press_q   <= '0;
      state_q   <= IDLE;
      dir_q     <= DIR_UP;
      cnt_q     <= '0;
      col_q     <= 5'(START_COL);
      row_q     <= 4'(START_ROW);
      in_frog_q <= 1'b0;
      win_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FROG_SCORE_EN
      score_q   <= '0;
`endif
    end else begin
      arm_q     <= arm_d;
      press_q   <= press_d;
      state_q   <= state_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      in_frog_q <= in_frog_d;
      win_q     <= win_d;
      busy_q    <= busy_d;
`ifdef FROG_SCORE_EN
      score_q   <= score_d;
`endif
    end
  end

  assign frog_col  = col_q;
  assign frog_row  = row_q;
  assign in_frog   = in_frog_q;
  assign win_pulse = win_q;
  assign busy      = busy_q;
`ifdef FROG_SCORE_EN
  assign score     = score_q;
`endif

endmodule

// File: tb/tb_frog_controller.sv
// Directed bench for frog_controller: moves, clamping, cooldown,
// win/respawn, in_frog window and mid-operation reset.
module tb_frog_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic [9:0] h_counter = '0;
  logic [9:0] v_counter = '0;
  logic [4:0] frog_col;
  logic [3:0] frog_row;
  logic       in_frog;
  logic       win_pulse;
  logic       busy;
`ifdef FROG_SCORE_EN
  logic [3:0] score;
`endif

  int checks = 0;
  int errors = 0;

  frog_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .h_counter   (h_counter),
    .v_counter   (v_counter),
    .frog_col    (frog_col),
    .frog_row    (frog_row),
    .in_frog     (in_frog),
    .win_pulse   (win_pulse),
    .busy        (busy)
`ifdef FROG_SCORE_EN
    ,
    .score       (score)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {up,down,left,right} high for one cycle, then wait until PENDING
  task automatic press(input logic [3:0] m);
    {btn_up, btn_down, btn_left, btn_right} = m;
    tick();
    {btn_up, btn_down, btn_left, btn_right} = 4'b0;
    tick();
  endtask

  // leaves the bench one cycle after the frame_start pulse
  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      tick();
      tick();
      frame();
    end
    tick();
  endtask

  task automatic move(input logic [3:0] m);
    press(m);
    frame();
    frames(8);
  endtask

  logic [9:0] hv [8];
  logic [9:0] vv [8];
  logic       ev [8];

  initial begin
    hv = '{10'd320, 10'd351, 10'd319, 10'd352,
           10'd320, 10'd351, 10'd335, 10'd0};
    vv = '{10'd448, 10'd479, 10'd448, 10'd479,
           10'd447, 10'd480, 10'd460, 10'd448};
    ev = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_col", frog_col, 10);
    chk("rst_row", frog_row, 14);
    chk("rst_busy", busy, 0);
    chk("rst_win", win_pulse, 0);
    chk("rst_in_frog", in_frog, 0);
`ifdef FROG_SCORE_EN
    chk("rst_score", score, 0);
`endif

    frames(3);
    chk("idle_col", frog_col, 10);
    chk("idle_row", frog_row, 14);
    chk("idle_busy", busy, 0);

    h_counter = 10'd320;
    v_counter = 10'd448;
    chk("in_frog_latency", in_frog, 0);
    tick();
    chk("in_frog_after1", in_frog, 1);
    for (int i = 0; i < 8; i++) begin
      h_counter = hv[i];
      v_counter = vv[i];
      tick();
      chk("in_frog_vec", in_frog, 32'(ev[i]));
    end

    // down at bottom row: clamped, still cools down
    press(4'b0100);
    chk("down_busy_pend", busy, 1);
    frame();
    chk("down_clamp_row", frog_row, 14);
    chk("down_busy_cd", busy, 1);
    frames(7);
    chk("down_busy_7", busy, 1);
    frames(1);
    chk("down_busy_8", busy, 0);

    // press latency: PENDING two cycles after the button edge
    btn_up = 1'b1;
    tick();
    btn_up = 1'b0;
    chk("press_lat_n1", busy, 0);
    tick();
    chk("press_lat_n2", busy, 1);
    chk("up_row_before", frog_row, 14);
    frame();
    chk("up_row13", frog_row, 13);
    frames(2);
    press(4'b1000);
    frames(5);
    chk("cd_busy_7", busy, 1);
    chk("cd_ignored_row", frog_row, 13);
    frames(1);
    chk("cd_busy_8", busy, 0);
    chk("cd_row_still", frog_row, 13);
    press(4'b1000);
    frame();
    chk("up_row12", frog_row, 12);
    frames(8);

    press(4'b1010);
    frame();
    chk("prio_row", frog_row, 11);
    chk("prio_col", frog_col, 10);
    frames(8);

    btn_up = 1'b1;
    tick();
    tick();
    frame();
    chk("hold_row", frog_row, 10);
    frames(40);
    btn_up = 1'b0;
    tick();
    chk("hold_row_after", frog_row, 10);
    chk("hold_busy", busy, 0);

    repeat (9) move(4'b0001);
    chk("right_col19", frog_col, 19);
    press(4'b0001);
    frame();
    chk("right_clamp_col", frog_col, 19);
    chk("right_clamp_busy", busy, 1);
    frames(3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_cd_busy", busy, 0);
    chk("rst_cd_col", frog_col, 10);
    chk("rst_cd_row", frog_row, 14);
    chk("rst_cd_win", win_pulse, 0);

    tick();
    repeat (13) move(4'b1000);
    chk("pre_win_row", frog_row, 1);
    press(4'b1000);
    chk("pre_win_pulse", win_pulse, 0);
    frame();
    chk("win_pulse", win_pulse, 1);
    chk("win_row", frog_row, 0);
    chk("win_busy", busy, 1);
`ifdef FROG_SCORE_EN
    chk("win_score", score, 1);
`endif
    tick();
    chk("win_pulse_1cyc", win_pulse, 0);
    frames(59);
    chk("win_hold_busy", busy, 1);
    chk("win_hold_row", frog_row, 0);
    frames(1);
    chk("respawn_row", frog_row, 14);
    chk("respawn_col", frog_col, 10);
    chk("respawn_busy", busy, 0);

    repeat (13) move(4'b1000);
    press(4'b1000);
    frame();
    chk("win2_pulse", win_pulse, 1);
    btn_up = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_win_pulse", win_pulse, 0);
    chk("rst_win_busy", busy, 0);
    chk("rst_win_row", frog_row, 14);
    chk("rst_win_col", frog_col, 10);
`ifdef FROG_SCORE_EN
    chk("rst_win_score", score, 0);
`endif
    tick();
    tick();
    frames(2);
    chk("held_thru_rst_busy", busy, 0);
    chk("held_thru_rst_row", frog_row, 14);
    btn_up = 1'b0;
    tick();

`ifdef FROG_SCORE_EN
    repeat (16) begin
      repeat (14) move(4'b1000);
      frames(52);
    end
    chk("score_sat", score, 15);
    chk("score_row", frog_row, 14);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frog_controller.md
# frog_controller

Sequences the player frog on the 20×15 grid of 32-pixel cells that the VGA pixel pipeline draws. It converts direction button presses into single-cell moves and applies each move only at a frame boundary. It enforces a per-move cooldown, clamps moves at the grid edges, and handles the win/respawn sequence when the frog reaches the top row. It produces the frog's cell coordinates and a registered per-pixel `in_frog` flag for the colour mux.

## Interface
- `GRID_SIZE`, 32: cell edge in pixels (power of two).
- `GRID_COLS`, 20: columns.
- `GRID_ROWS`, 15: rows.
- `START_COL`, 10: spawn column.
- `START_ROW`, 14: spawn row.
- `COOLDOWN_FRAMES`, 8: frames after a move before the next press is accepted (≥1).
- `WIN_FRAMES`, 60: frames held in the win state before respawn (≥1).

Ports:
- `clk` in 1: pixel clock; only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse at start of vertical blanking.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: synchronised, debounced, active-high levels.
- `h_counter` in 10: current pixel x.
- `v_counter` in 10: current pixel y.
- `frog_col` out 5: current column.
- `frog_row` out 4: current row.
- `in_frog` out 1: registered; pixel lies in the frog cell.
- `win_pulse` out 1: one-cycle pulse on reaching row 0.
- `busy` out 1: high when not IDLE (presses are being ignored).
- `score` out 4: wins count, saturating at 15 (only with `FROG_SCORE_EN`).

## Operation
- Per-button rising-edge detect with one register stage per button. A held button yields exactly one press.
- States and transitions:
  - IDLE: on any press edge, latch the direction and go to PENDING. Simultaneous edges use priority up > down > left > right; the others are discarded.
  - PENDING: wait for `frame_start`. On it, apply the move. If the new row is 0, go to WIN; otherwise go to COOLDOWN. Press edges in PENDING are discarded.
  - COOLDOWN: counter is loaded with `COOLDOWN_FRAMES` on entry and decremented on each `frame_start`. Go to IDLE on the `frame_start` that brings it to 0. Press edges are discarded.
  - WIN: counter is loaded with `WIN_FRAMES` and decremented on each `frame_start`. On the `frame_start` that brings it to 0, reload `START_COL`/`START_ROW` and go to IDLE.
- Move rules:
  - up = row−1; down = row+1; left = col−1; right = col+1.
  - Any move that would leave the grid (row<0, row>GRID_ROWS−1, col<0, col>GRID_COLS−1) leaves the position unchanged but still enters COOLDOWN.
- `in_frog`:
  - Compute `h_counter/GRID_SIZE`, `v_counter/GRID_SIZE` by shift.
  - Flag is 1 when both match `frog_col`/`frog_row` and `h_counter<GRID_COLS*GRID_SIZE`, `v_counter<GRID_ROWS*GRID_SIZE`; otherwise 0.
- Reset values:
  - State IDLE; `frog_col=START_COL`, `frog_row=START_ROW`.
  - `in_frog=0`, `win_pulse=0`, `busy=0`, `score=0`.
  - Edge-detect registers = 0: a button held through reset release does not generate a press.

## Timing
- Press edge: the button goes high in cycle n; the edge register detects it at n+1; state is PENDING from n+2.
- Move: `frame_start` arrives in PENDING at cycle m; `frog_col`/`frog_row` update and the new state is entered at m+1.
- Win: `win_pulse` is high during cycle m+1 only.
- `frame_start` in the same cycle the IDLE→PENDING transition occurs is not used for that move. The move waits for the next `frame_start`.
- Move-to-move spacing is at least `COOLDOWN_FRAMES` frame starts.
- Win hold lasts exactly `WIN_FRAMES` frame starts after the win frame. The position change is visible at the cycle after the final `frame_start`.
- `in_frog` has 1-cycle latency from `h_counter`/`v_counter`. Position changes occur in blanking, so no visible tearing.
- Reset asserted mid-operation (any state) returns all outputs to reset values on the next clock edge.

## Configuration
- `FROG_SCORE_EN` defined:
  - The `score` port and a 4-bit counter exist.
  - The counter increments in the same cycle as `win_pulse` and saturates at 15.
  - It clears only on reset.
- `FROG_SCORE_EN` undefined: no `score` port, no counter. All other behaviour is identical.

## Test plan
- Reset, then idle for 3 frames → `frog_col=10`, `frog_row=14`, `busy=0`. `in_frog=1` exactly for pixels x 320–351, y 448–479, one cycle after the counters.
- `btn_up` pulse, then 1 frame → `frog_row=13` one cycle after `frame_start`. A second `btn_up` within 8 frames is ignored; one after 8 frames gives `frog_row=12`.
- Press at `frog_row=14` with `btn_down`, and at `frog_col=19` with `btn_right` → position unchanged, `busy=1` for 8 frames.
- `btn_up` and `btn_left` rising in the same cycle → only `frog_row` decrements, `frog_col` stays 10. Holding `btn_up` for 40 frames → exactly one move.
- 14 spaced up-presses → `win_pulse` high for one cycle when `frog_row=0`. After 60 frames, position is (10,14) and `busy=0`. With `FROG_SCORE_EN`, `score=1`; 16 wins → `score=15`.
- Deassert `rst_n` for one cycle while in COOLDOWN and in WIN → next cycle state IDLE, position (10,14), `win_pulse=0`.
